// File: rtl/cpu_core_mc.sv
// ---------------------------------------------------------------------------
// cpu_core_mc
//   Parametrised multi-cycle CPU core. Each instruction is fetched from a
//   synchronous ROM into a registered IR and then walks through a fixed
//   state sequence.
//     FETCH -> DECODE -> READ_A -> READ_B -> EXEC -> WRITE -> FETCH  (ALU ops)
//     FETCH -> DECODE -> READ_B -> EXEC -> WRITE -> FETCH            (MOV)
//     FETCH -> DECODE -> FETCH                        (NOP / JMP / JZ / unknown)
//     FETCH -> DECODE -> HALT                         (HALT, sticky)
//   ALU and MOV instructions are memory-to-memory. They use a single-port
//   synchronous RAM and an external combinational ALU.
//
// Optional build macro:
//   CPU_STEP_EN - adds a 'step' input. FETCH idles with all strobes low
//                 until step=1 is sampled. One instruction runs per pulse.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-low reset
//   step            in   single-step enable (CPU_STEP_EN builds only)
//   rom_address     out  instruction address (always equals pc)
//   rom_read_enable out  ROM read strobe (high in FETCH)
//   rom_data        in   ROM data, valid one cycle after the strobe
//   ram_read        out  RAM read strobe (READ_A / READ_B)
//   ram_read_addr   out  RAM read address (dest in READ_A, src in READ_B)
//   ram_data_out    in   RAM read data, valid one cycle after the strobe
//   ram_write       out  RAM write strobe (WRITE)
//   ram_write_addr  out  RAM write address (dest)
//   ram_data_in     out  RAM write data (ALU result, or B for MOV)
//   alu_op          out  opcode shown to the ALU in EXEC and WRITE
//   alu_a / alu_b   out  operand registers A (mem[dest]) and B (mem[src])
//   alu_result      in   combinational ALU result
//   pc              out  program counter
//   state           out  FSM state encoding
//   zero            out  zero flag from the last ALU op
//   halted          out  high in the HALT state
// ---------------------------------------------------------------------------
module cpu_core_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int PC_W   = 8,
    parameter int OPC_W  = 4,
    localparam int INSTR_W = OPC_W + 2*ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CPU_STEP_EN
    input  logic               step,
`endif
    output logic [PC_W-1:0]    rom_address,
    output logic               rom_read_enable,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               ram_read,
    output logic [ADDR_W-1:0]  ram_read_addr,
    input  logic [DATA_W-1:0]  ram_data_out,
    output logic               ram_write,
    output logic [ADDR_W-1:0]  ram_write_addr,
    output logic [DATA_W-1:0]  ram_data_in,
    output logic [OPC_W-1:0]   alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               zero,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_READ_A = 3'd2,
        S_READ_B = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(4'h8);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(4'hF);

    // Level of the ROM strobe on re-entering FETCH. In step mode FETCH
    // always comes back idle, so each instruction needs a fresh step.
`ifdef CPU_STEP_EN
    localparam logic FETCH_ARM = 1'b0;
`else
    localparam logic FETCH_ARM = 1'b1;
`endif

    // ADD, SUB, AND, OR and XOR have contiguous opcodes.
    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic take_jump(input logic [OPC_W-1:0] op, input logic z);
        return (op == OP_JMP) || ((op == OP_JZ) && z);
    endfunction

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic                zero_q;
    logic                halted_q;
    logic                rom_rd_q;
    logic                ram_rd_q;
    logic [ADDR_W-1:0]   ram_raddr_q;
    logic                ram_wr_q;
    logic [ADDR_W-1:0]   ram_waddr_q;
    logic [OPC_W-1:0]    alu_op_q;
    logic                fetch_go;

    // Fields of the word arriving from the ROM during DECODE.
    logic [OPC_W-1:0]    dec_opc;
    logic [ADDR_W-1:0]   dec_dest;
    logic [ADDR_W-1:0]   dec_src;
    logic [PC_W-1:0]     dec_target;

    // Fields of the latched instruction, used from READ_A onwards.
    logic [OPC_W-1:0]    ir_opc;
    logic [ADDR_W-1:0]   ir_dest;
    logic [ADDR_W-1:0]   ir_src;

    assign dec_opc    = rom_data[INSTR_W-1 -: OPC_W];
    assign dec_dest   = rom_data[2*ADDR_W-1:ADDR_W];
    assign dec_src    = rom_data[ADDR_W-1:0];
    assign dec_target = rom_data[PC_W-1:0];

    assign ir_opc  = ir[INSTR_W-1 -: OPC_W];
    assign ir_dest = ir[2*ADDR_W-1:ADDR_W];
    assign ir_src  = ir[ADDR_W-1:0];

`ifdef CPU_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Control and strobes are registered together with the state. A strobe
    // is set on the edge that enters its state and cleared on the edge that
    // leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir          <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            zero_q      <= 1'b0;
            halted_q    <= 1'b0;
            rom_rd_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            ram_raddr_q <= '0;
            ram_wr_q    <= 1'b0;
            ram_waddr_q <= '0;
            alu_op_q    <= '0;
        end else begin
            case (state_q)
                // ---- FETCH: ROM samples pc while the strobe is high ----
                S_FETCH: begin
                    // Reset clears the strobe, and step mode re-enters
                    // FETCH idle. In both cases the strobe is raised first.
                    // The ROM word is only expected once the strobe has
                    // been high for a full cycle.
                    if (rom_rd_q) begin
                        rom_rd_q <= 1'b0;
                        state_q  <= S_DECODE;
                    end else if (fetch_go) begin
                        rom_rd_q <= 1'b1;
                    end
                end

                // ---- DECODE: latch IR, advance pc, pick the path ----
                S_DECODE: begin
                    ir   <= rom_data;
                    pc_q <= pc_q + PC_W'(1);
                    if (is_alu(dec_opc)) begin
                        state_q     <= S_READ_A;
                        ram_rd_q    <= 1'b1;
                        ram_raddr_q <= dec_dest;
                    end else if (dec_opc == OP_MOV) begin
                        // MOV never needs mem[dest], so READ_A is skipped.
                        state_q     <= S_READ_B;
                        ram_rd_q    <= 1'b1;
                        ram_raddr_q <= dec_src;
                    end else if (dec_opc == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= S_FETCH;
                        rom_rd_q <= FETCH_ARM;
                        if (take_jump(dec_opc, zero_q)) begin
                            pc_q <= dec_target;
                        end
                    end
                end

                // ---- READ_A: RAM samples dest ----
                S_READ_A: begin
                    state_q     <= S_READ_B;
                    ram_raddr_q <= ir_src;
                end

                // ---- READ_B: mem[dest] arrives, RAM samples src ----
                S_READ_B: begin
                    if (is_alu(ir_opc)) begin
                        a_reg <= ram_data_out;
                    end
                    state_q     <= S_EXEC;
                    ram_rd_q    <= 1'b0;
                    ram_raddr_q <= '0;
                    alu_op_q    <= ir_opc;
                end

                // ---- EXEC: mem[src] arrives into B ----
                S_EXEC: begin
                    b_reg       <= ram_data_out;
                    state_q     <= S_WRITE;
                    ram_wr_q    <= 1'b1;
                    ram_waddr_q <= ir_dest;
                end

                // ---- WRITE: RAM stores ram_data_in at dest ----
                S_WRITE: begin
                    if (is_alu(ir_opc)) begin
                        zero_q <= (alu_result == '0);
                    end
                    state_q     <= S_FETCH;
                    ram_wr_q    <= 1'b0;
                    ram_waddr_q <= '0;
                    alu_op_q    <= '0;
                    rom_rd_q    <= FETCH_ARM;
                end

                S_HALT: begin
                    state_q <= S_HALT;
                end

                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Write data depends on B, which is only loaded at the end of EXEC, so
    // it is selected combinationally in WRITE. It is held at zero otherwise.
    always_comb begin
        ram_data_in = '0;
        if (state_q == S_WRITE) begin
            ram_data_in = (ir_opc == OP_MOV) ? b_reg : alu_result;
        end
    end

    assign rom_address     = pc_q;
    assign rom_read_enable = rom_rd_q;
    assign ram_read        = ram_rd_q;
    assign ram_read_addr   = ram_raddr_q;
    assign ram_write       = ram_wr_q;
    assign ram_write_addr  = ram_waddr_q;
    assign alu_op          = alu_op_q;
    assign alu_a           = a_reg;
    assign alu_b           = b_reg;
    assign pc              = pc_q;
    assign state           = state_q;
    assign zero            = zero_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_cpu_core_mc.sv
// ---------------------------------------------------------------------------
// tb_cpu_core_mc
//   Directed bench for cpu_core_mc at default parameters. It models the
//   synchronous ROM, the synchronous RAM and the combinational ALU. The
//   memories are preloaded through load ports while reset is held.
//   Set CPU_STEP_EN to build the step-mode variant.
// ---------------------------------------------------------------------------
module tb_cpu_core_mc;

    logic        clk;
    logic        reset;
`ifdef CPU_STEP_EN
    logic        step;
`endif
    logic [7:0]  rom_address;
    logic        rom_read_enable;
    logic [15:0] rom_data;
    logic        ram_read;
    logic [5:0]  ram_read_addr;
    logic [15:0] ram_data_out;
    logic        ram_write;
    logic [5:0]  ram_write_addr;
    logic [15:0] ram_data_in;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        zero;
    logic        halted;

    // bench-side memory models and their load ports
    logic [15:0] rom [0:255];
    logic [15:0] mem [0:63];
    logic        rom_we;
    logic [7:0]  rom_wa;
    logic [15:0] rom_wd;
    logic        mem_we;
    logic [5:0]  mem_wa;
    logic [15:0] mem_wd;

    int checks;
    int errors;

    cpu_core_mc dut (
        .clk             (clk),
        .reset           (reset),
`ifdef CPU_STEP_EN
        .step            (step),
`endif
        .rom_address     (rom_address),
        .rom_read_enable (rom_read_enable),
        .rom_data        (rom_data),
        .ram_read        (ram_read),
        .ram_read_addr   (ram_read_addr),
        .ram_data_out    (ram_data_out),
        .ram_write       (ram_write),
        .ram_write_addr  (ram_write_addr),
        .ram_data_in     (ram_data_in),
        .alu_op          (alu_op),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result      (alu_result),
        .pc              (pc),
        .state           (state),
        .zero            (zero),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_we) rom[rom_wa] <= rom_wd;
        if (rom_read_enable) rom_data <= rom[rom_address];
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        else if (ram_write) mem[ram_write_addr] <= ram_data_in;
        if (ram_read) ram_data_out <= mem[ram_read_addr];
    end

    always_comb begin
        alu_result = 16'h0000;
        case (alu_op)
            4'h1: alu_result = alu_a + alu_b;
            4'h2: alu_result = alu_a - alu_b;
            4'h3: alu_result = alu_a & alu_b;
            4'h4: alu_result = alu_a | alu_b;
            4'h5: alu_result = alu_a ^ alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic load_rom(input logic [7:0] a, input logic [15:0] d);
        rom_we = 1'b1; rom_wa = a; rom_wd = d;
        tick(1);
        rom_we = 1'b0;
    endtask

    task automatic load_mem(input logic [5:0] a, input logic [15:0] d);
        mem_we = 1'b1; mem_wa = a; mem_wd = d;
        tick(1);
        mem_we = 1'b0;
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        tick(2);
    endtask

    task automatic release_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        #2 reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h want 00", pc); end
        checks++; if ({rom_read_enable, ram_read, ram_write} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {rom_read_enable, ram_read, ram_write}); end
        checks++; if ({zero, halted} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {zero, halted}); end
        checks++; if ({alu_a, alu_b, ram_data_in, alu_op} !== 52'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {alu_a, alu_b, ram_data_in, alu_op}); end
        @(negedge clk);
        tick(3);
        checks++; if ({state, rom_read_enable} !== 4'b0000) begin errors++; $display("FAIL rst_hold: got %b want 0000", {state, rom_read_enable}); end
    endtask

`ifndef CPU_STEP_EN
    task automatic test_add();
        hold_reset();
        load_rom(8'h00, 16'h10C4);   // ADD dest=3 src=4
        load_rom(8'h01, 16'h8030);   // JZ 0x30, not taken since zero=0
        load_mem(6'd3, 16'd5);
        load_mem(6'd4, 16'd7);
        release_reset();
        tick(1);
        checks++; if ({state, rom_read_enable, rom_address} !== {3'd0, 1'b1, 8'h00}) begin errors++; $display("FAIL add_fetch: got st=%0d en=%b a=%h want 0 1 00", state, rom_read_enable, rom_address); end
        tick(2);
        checks++; if ({state, ram_read, ram_read_addr, pc} !== {3'd2, 1'b1, 6'd3, 8'h01}) begin errors++; $display("FAIL add_read_a: got st=%0d rd=%b a=%0d pc=%h want 2 1 3 01", state, ram_read, ram_read_addr, pc); end
        tick(1);
        checks++; if ({state, ram_read, ram_read_addr} !== {3'd3, 1'b1, 6'd4}) begin errors++; $display("FAIL add_read_b: got st=%0d rd=%b a=%0d want 3 1 4", state, ram_read, ram_read_addr); end
        tick(1);
        checks++; if ({state, ram_read, alu_op, alu_a} !== {3'd4, 1'b0, 4'h1, 16'd5}) begin errors++; $display("FAIL add_exec: got st=%0d rd=%b op=%h a=%0d want 4 0 1 5", state, ram_read, alu_op, alu_a); end
        tick(1);
        checks++; if ({state, ram_write, ram_read, ram_write_addr, ram_data_in, alu_b} !== {3'd5, 1'b1, 1'b0, 6'd3, 16'd12, 16'd7}) begin errors++; $display("FAIL add_write: got st=%0d wr=%b rd=%b a=%0d d=%0d b=%0d want 5 1 0 3 12 7", state, ram_write, ram_read, ram_write_addr, ram_data_in, alu_b); end
        tick(1);
        checks++; if (mem[3] !== 16'd12) begin errors++; $display("FAIL add_result: got %0d want 12", mem[3]); end
        checks++; if ({state, zero, pc, ram_write, alu_op} !== {3'd0, 1'b0, 8'h01, 1'b0, 4'h0}) begin errors++; $display("FAIL add_done: got st=%0d z=%b pc=%h wr=%b op=%h want 0 0 01 0 0", state, zero, pc, ram_write, alu_op); end
        tick(2);
        checks++; if ({state, pc} !== {3'd0, 8'h02}) begin errors++; $display("FAIL jz_not_taken: got st=%0d pc=%h want 0 02", state, pc); end
    endtask

    task automatic test_sub_jz();
        hold_reset();
        load_rom(8'h00, 16'h2042);   // SUB dest=1 src=2
        load_rom(8'h01, 16'h8020);   // JZ 0x20
        load_mem(6'd1, 16'd9);
        load_mem(6'd2, 16'd9);
        release_reset();
        tick(7);
        checks++; if ({mem[1], zero, pc} !== {16'd0, 1'b1, 8'h01}) begin errors++; $display("FAIL sub_zero: got m=%0d z=%b pc=%h want 0 1 01", mem[1], zero, pc); end
        tick(2);
        checks++; if ({state, pc} !== {3'd0, 8'h20}) begin errors++; $display("FAIL jz_taken: got st=%0d pc=%h want 0 20", state, pc); end
    endtask

    task automatic test_back_to_back();
        hold_reset();
        load_rom(8'h00, 16'h51C7);   // XOR dest=7 src=7
        load_rom(8'h01, 16'h4209);   // OR  dest=8 src=9
        load_mem(6'd7, 16'h5A5A);
        load_mem(6'd8, 16'h00F0);
        load_mem(6'd9, 16'h0F00);
        release_reset();
        tick(7);
        checks++; if ({mem[7], zero} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL xor_same: got m=%h z=%b want 0000 1", mem[7], zero); end
        tick(6);
        checks++; if ({mem[8], zero, pc, state} !== {16'h0FF0, 1'b0, 8'h02, 3'd0}) begin errors++; $display("FAIL or_next: got m=%h z=%b pc=%h st=%0d want 0ff0 0 02 0", mem[8], zero, pc, state); end
    endtask

    task automatic test_mov_halt();
        int rd5;
        int bad;
        rd5 = 0;
        bad = 0;
        hold_reset();
        load_rom(8'h00, 16'h6146);   // MOV dest=5 src=6
        load_rom(8'h01, 16'hF000);   // HALT
        load_mem(6'd5, 16'h1111);
        load_mem(6'd6, 16'hBEEF);
        release_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (ram_read && ram_read_addr == 6'd5) rd5++;
            if (ram_read && ram_write) bad++;
        end
        checks++; if (rd5 !== 0) begin errors++; $display("FAIL mov_no_dest_read: got %0d reads want 0", rd5); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mov_rd_wr_overlap: got %0d want 0", bad); end
        checks++; if ({mem[5], state, zero} !== {16'hBEEF, 3'd0, 1'b0}) begin errors++; $display("FAIL mov_result: got m=%h st=%0d z=%b want beef 0 0", mem[5], state, zero); end
        tick(2);
        checks++; if ({state, halted, pc} !== {3'd6, 1'b1, 8'h02}) begin errors++; $display("FAIL halt_enter: got st=%0d h=%b pc=%h want 6 1 02", state, halted, pc); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (state != 3'd6 || !halted || rom_read_enable || ram_read || ram_write) bad++;
        end
        checks++; if ({bad, pc} !== {32'd0, 8'h02}) begin errors++; $display("FAIL halt_sticky: got bad=%0d pc=%h want 0 02", bad, pc); end
    endtask

    task automatic test_pc_wrap();
        hold_reset();
        load_rom(8'h00, 16'hB123);   // unknown opcode -> NOP
        load_rom(8'h01, 16'h70FF);   // JMP 0xFF
        load_rom(8'hFF, 16'h0000);   // NOP
        release_reset();
        tick(3);
        checks++; if ({state, pc, ram_read, ram_write} !== {3'd0, 8'h01, 1'b0, 1'b0}) begin errors++; $display("FAIL unknown_nop: got st=%0d pc=%h rd=%b wr=%b want 0 01 0 0", state, pc, ram_read, ram_write); end
        tick(2);
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL jmp_ff: got %h want ff", pc); end
        tick(2);
        checks++; if ({state, pc} !== {3'd0, 8'h00}) begin errors++; $display("FAIL pc_wrap: got st=%0d pc=%h want 0 00", state, pc); end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        load_rom(8'h00, 16'h2042);   // SUB 1,2 -> zero=1
        load_rom(8'h01, 16'h10C4);   // ADD 3,4
        load_mem(6'd1, 16'd9);
        load_mem(6'd2, 16'd9);
        load_mem(6'd3, 16'd5);
        load_mem(6'd4, 16'd7);
        release_reset();
        tick(12);
        checks++; if ({state, ram_write, zero} !== {3'd5, 1'b1, 1'b1}) begin errors++; $display("FAIL mid_pre: got st=%0d wr=%b z=%b want 5 1 1", state, ram_write, zero); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({state, pc, zero, ram_write, ram_write_addr, ram_data_in, alu_op} !== {3'd0, 8'h00, 1'b0, 1'b0, 6'd0, 16'd0, 4'h0}) begin errors++; $display("FAIL mid_async: got st=%0d pc=%h z=%b wr=%b a=%0d d=%h op=%h want all 0", state, pc, zero, ram_write, ram_write_addr, ram_data_in, alu_op); end
        @(negedge clk);
        tick(3);
        checks++; if (mem[3] !== 16'd5) begin errors++; $display("FAIL mid_no_write: got %0d want 5", mem[3]); end
        release_reset();
    endtask
`endif

`ifdef CPU_STEP_EN
    task automatic test_step();
        step = 1'b0;
        hold_reset();
        load_rom(8'h00, 16'h10C4);   // ADD dest=3 src=4
        load_rom(8'h01, 16'h10C4);
        load_mem(6'd3, 16'd5);
        load_mem(6'd4, 16'd7);
        release_reset();
        tick(20);
        checks++; if ({state, rom_read_enable, pc} !== {3'd0, 1'b0, 8'h00}) begin errors++; $display("FAIL step_idle: got st=%0d en=%b pc=%h want 0 0 00", state, rom_read_enable, pc); end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        checks++; if ({state, rom_read_enable} !== {3'd0, 1'b1}) begin errors++; $display("FAIL step_arm: got st=%0d en=%b want 0 1", state, rom_read_enable); end
        tick(6);
        checks++; if ({mem[3], pc, state, rom_read_enable} !== {16'd12, 8'h01, 3'd0, 1'b0}) begin errors++; $display("FAIL step_one: got m=%0d pc=%h st=%0d en=%b want 12 01 0 0", mem[3], pc, state, rom_read_enable); end
        tick(20);
        checks++; if ({pc, state, mem[3]} !== {8'h01, 3'd0, 16'd12}) begin errors++; $display("FAIL step_hold: got pc=%h st=%0d m=%0d want 01 0 12", pc, state, mem[3]); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        rom_we = 1'b0; rom_wa = 8'h00; rom_wd = 16'h0000;
        mem_we = 1'b0; mem_wa = 6'd0;  mem_wd = 16'h0000;
`ifdef CPU_STEP_EN
        step = 1'b0;
`endif
        test_reset();
`ifdef CPU_STEP_EN
        test_step();
`else
        test_add();
        test_sub_jz();
        test_back_to_back();
        test_mov_halt();
        test_pc_wrap();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
